// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_DATA   = 4'd7,
    RD_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } tgt_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_rsp_if.sv
// Bus-side pins of the I2C target: pad levels in, open-drain drives and IRQ out.
interface i2c_target_rsp_if;
  logic scl_i;
  logic sda_i;
  logic scl_o;
  logic sda_o;
  logic IRQ;

  modport slave  (input scl_i, sda_i, output scl_o, sda_o, IRQ);
  modport master (output scl_i, sda_i, input scl_o, sda_o, IRQ);
endinterface

// File: rtl/i2c_tgt_sync.sv
// Pad synchronizers, registered SCL edge detection and START/STOP detection.
module i2c_tgt_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_s_q;
  logic scl_edge_s, sda_rise_s, sda_fall_s;

  assign scl_edge_s = scl_sync_q ^ scl_prev_q;
  assign sda_rise_s = sda_sync_q & ~sda_prev_q;
  assign sda_fall_s = ~sda_sync_q & sda_prev_q;

  // Two-flop synchronizers plus one cycle of history; reset to the idle bus level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Registered event pulses; an SCL edge in the same cycle suppresses START/STOP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_s_q    <= 1'b1;
    end else begin
      scl_rise_q <= scl_sync_q & ~scl_prev_q;
      scl_fall_q <= ~scl_sync_q & scl_prev_q;
      start_q    <= sda_fall_s & scl_sync_q & ~scl_edge_s;
      stop_q     <= sda_rise_s & scl_sync_q & ~scl_edge_s;
      sda_s_q    <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_s     = sda_s_q;
endmodule

// File: rtl/i2c_target_rsp.sv
// I2C target responder: address match, pointer load, auto-incrementing byte memory.
module i2c_target_rsp
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]  TGT_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic            i2c_core_clk,
  input  logic            i2c_rst,
  i2c_target_rsp_if.slave bus
);
  localparam int unsigned PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic             scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_s;
  tgt_state_e       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic             sda_q, sda_d;
  logic             irq_q, irq_d;
  logic             dirty_q, dirty_d;
  logic             rw_q, rw_d;
  logic             acked_q, acked_d;
  logic             mem_we_s;
  logic [7:0]       byte_s;
  logic [7:0]       rd_byte_s;
  logic [PTR_W-1:0] ptr_inc_s;

  i2c_tgt_sync u_sync (
    .clk_i     (i2c_core_clk),
    .rst_i     (i2c_rst),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_det_s),
    .stop_det  (stop_det_s),
    .sda_s     (sda_s)
  );

  // byte_s is the full byte as it stands once the current rise is shifted in
  assign byte_s    = {shift_q[6:0], sda_s};
  assign rd_byte_s = mem_q[ptr_q];
  assign ptr_inc_s = ptr_q + PTR_W'(1);

  // Next-state and datapath decode; STOP beats START beats bit-level activity
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    sda_d     = sda_q;
    rw_d      = rw_q;
    acked_d   = acked_q;
    dirty_d   = dirty_q;
    irq_d     = 1'b0;
    mem_we_s  = 1'b0;
    if (stop_det_s) begin
      state_d   = IDLE;
      sda_d     = I2C_NACK;
      irq_d     = dirty_q;
      dirty_d   = 1'b0;
      bit_cnt_d = 3'd0;
      acked_d   = 1'b0;
    end else if (start_det_s) begin
      state_d   = ADDR;
      sda_d     = I2C_NACK;
      dirty_d   = 1'b0;
      bit_cnt_d = 3'd0;
      acked_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: begin
          sda_d = I2C_NACK;
        end
        ADDR, PTR, WR_DATA: begin
          if (scl_rise_s) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_s[7:1] == TGT_ADDR) begin
                  rw_d    = byte_s[0];
                  state_d = ADDR_ACK;
                end else begin
                  state_d = IDLE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = byte_s[PTR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                mem_we_s = 1'b1;
                ptr_d    = ptr_inc_s;
                dirty_d  = 1'b1;
                state_d  = WR_ACK;
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        // First fall after the 8th bit opens the ACK, the next fall closes it
        ADDR_ACK: begin
          if (scl_fall_s) begin
            if (sda_q == I2C_NACK) begin
              sda_d = I2C_ACK;
            end else if (rw_q) begin
              shift_d   = rd_byte_s;
              sda_d     = rd_byte_s[7];
              bit_cnt_d = 3'd0;
              state_d   = RD_DATA;
            end else begin
              sda_d     = I2C_NACK;
              bit_cnt_d = 3'd0;
              state_d   = PTR;
            end
          end else begin
            sda_d = sda_q;
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_fall_s) begin
            if (sda_q == I2C_NACK) begin
              sda_d = I2C_ACK;
            end else begin
              sda_d     = I2C_NACK;
              bit_cnt_d = 3'd0;
              state_d   = WR_DATA;
            end
          end else begin
            sda_d = sda_q;
          end
        end
        // Bit 7 is already on the bus at entry; each fall presents the next bit
        RD_DATA: begin
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_q == 3'd0) begin
              sda_d   = I2C_NACK;
              state_d = RD_ACK;
            end else begin
              sda_d = shift_q[3'd7 - bit_cnt_q];
            end
          end else begin
            sda_d = sda_q;
          end
        end
        RD_ACK: begin
          if (scl_rise_s) begin
            if (sda_s == I2C_ACK) begin
              ptr_d   = ptr_inc_s;
              acked_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall_s && acked_q) begin
            shift_d   = rd_byte_s;
            sda_d     = rd_byte_s[7];
            bit_cnt_d = 3'd0;
            acked_d   = 1'b0;
            state_d   = RD_DATA;
          end else begin
            sda_d = I2C_NACK;
          end
        end
        default: begin
          state_d = IDLE;
          sda_d   = I2C_NACK;
        end
      endcase
    end
  end

  // State, datapath and output registers; reset releases SDA immediately
  always_ff @(posedge i2c_core_clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      ptr_q     <= '0;
      sda_q     <= I2C_NACK;
      irq_q     <= 1'b0;
      dirty_q   <= 1'b0;
      rw_q      <= 1'b0;
      acked_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      sda_q     <= sda_d;
      irq_q     <= irq_d;
      dirty_q   <= dirty_d;
      rw_q      <= rw_d;
      acked_q   <= acked_d;
    end
  end

  // Register memory: cleared on reset, written on the rise sampling the 8th data bit
  always_ff @(posedge i2c_core_clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we_s) begin
      mem_q[ptr_q] <= byte_s;
    end
  end

  assign bus.scl_o = 1'b1;
  assign bus.sda_o = sda_q;
  assign bus.IRQ   = irq_q;
endmodule

// File: tb/tb_i2c_target_rsp.sv
// Directed bench: bit-banged controller, transaction-level memory model, per-cycle IRQ check.
module tb_i2c_target_rsp;
  import i2c_tgt_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int irq_due = -100;
  int irq_pulses = 0;
  int m_irq_cnt = 0;
  logic irq_prev = 1'b0;

  logic [7:0] m_mem [DEPTH];
  int         m_ptr = 0;
  logic       m_dirty = 1'b0;
  logic [7:0] wdata [4];
  logic [7:0] rd;
  logic       b;

  i2c_target_rsp_if ifc ();
  assign ifc.scl_i = scl_m & ifc.scl_o;
  assign ifc.sda_i = sda_m & ifc.sda_o;

  i2c_target_rsp #(.TGT_ADDR(7'h50), .MEM_DEPTH(DEPTH)) dut (
    .i2c_core_clk (clk),
    .i2c_rst      (rst),
    .bus          (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Per-cycle compare: SCL never pulled, IRQ high exactly on the predicted cycle
  always @(negedge clk) begin
    cyc++;
    chk("scl_o", 32'(ifc.scl_o), 32'd1);
    chk("irq_cycle", 32'(ifc.IRQ), 32'(cyc == irq_due));
    if (ifc.IRQ === 1'b1) begin
      irq_pulses++;
      chk("irq_width", 32'(irq_prev), 32'd0);
    end
    irq_prev = ifc.IRQ;
  end

  task automatic q();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; m_dirty = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1;
    if (m_dirty) begin
      irq_due = cyc + 5;
      m_irq_cnt++;
    end
    m_dirty = 1'b0;
    q(); q(); q();
  endtask

  task automatic write_bit(input logic v);
    sda_m = v; q();
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
  endtask

  task automatic read_bit(output logic v);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    v = ifc.sda_i; q();
    scl_m = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    chk(nm, 32'(a), 32'(exp_ack));
  endtask

  task automatic recv_byte(input logic ack, input string nm, output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      d[i] = v;
    end
    chk(nm, 32'(d), 32'(m_mem[m_ptr]));
    write_bit(ack);
    if (ack == I2C_ACK) m_ptr = (m_ptr + 1) % DEPTH;
  endtask

  // Full write transaction: address, pointer, n data bytes, STOP
  task automatic wr_txn(input logic [6:0] a, input logic [7:0] p, input int n);
    logic hit;
    hit = (a == 7'h50);
    bus_start();
    send_byte({a, 1'b0}, !hit, "addr_ack");
    send_byte(p, !hit, "ptr_ack");
    if (hit) m_ptr = p % DEPTH;
    for (int k = 0; k < n; k++) begin
      send_byte(wdata[k], !hit, "data_ack");
      if (hit) begin
        m_mem[m_ptr] = wdata[k];
        m_ptr = (m_ptr + 1) % DEPTH;
        m_dirty = 1'b1;
      end
    end
    bus_stop();
  endtask

  task automatic chk_model();
    chk("ptr", 32'(dut.ptr_q), 32'(m_ptr));
    for (int i = 0; i < DEPTH; i++) chk("mem", 32'(dut.mem_q[i]), 32'(m_mem[i]));
    chk("irq_count", 32'(irq_pulses), 32'(m_irq_cnt));
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
    m_dirty = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_o", 32'(ifc.sda_o), 32'd1);
    chk("rst_irq", 32'(ifc.IRQ), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk_model();
    rst = 1'b0;
    q();

    // Write 0xA5, 0x3C at pointer 3
    wdata[0] = 8'hA5; wdata[1] = 8'h3C;
    wr_txn(7'h50, 8'h03, 2);
    chk_model();
    chk("lit_mem3", 32'(dut.mem_q[3]), 32'h0000_00A5);
    chk("lit_mem4", 32'(dut.mem_q[4]), 32'h0000_003C);
    chk("lit_ptr5", 32'(dut.ptr_q), 32'd5);
    chk("lit_irq1", 32'(irq_pulses), 32'd1);

    // Pointer 2, repeated START, read three bytes ACK/ACK/NACK
    bus_start();
    send_byte(8'hA0, I2C_ACK, "rd_addr_w_ack");
    send_byte(8'h02, I2C_ACK, "rd_ptr_ack");
    m_ptr = 2;
    bus_start();
    send_byte(8'hA1, I2C_ACK, "rd_addr_r_ack");
    recv_byte(I2C_ACK, "rd_byte0", rd);
    chk("lit_rd0", 32'(rd), 32'h0000_0000);
    recv_byte(I2C_ACK, "rd_byte1", rd);
    chk("lit_rd1", 32'(rd), 32'h0000_00A5);
    recv_byte(I2C_NACK, "rd_byte2", rd);
    chk("lit_rd2", 32'(rd), 32'h0000_003C);
    bus_stop();
    chk_model();
    chk("lit_ptr4", 32'(dut.ptr_q), 32'd4);

    // Wrong address: never ACKed, memory untouched
    wdata[0] = 8'h77;
    wr_txn(7'h51, 8'h00, 1);
    chk_model();

    // Wrap at the top of memory
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    wr_txn(7'h50, 8'h0F, 2);
    chk_model();
    chk("lit_mem15", 32'(dut.mem_q[15]), 32'h0000_0011);
    chk("lit_mem0", 32'(dut.mem_q[0]), 32'h0000_0022);

    // Upper pointer bits ignored
    wr_txn(7'h50, 8'hF3, 0);
    chk_model();
    chk("lit_ptr3", 32'(dut.ptr_q), 32'd3);

    // STOP after four data bits: nothing written
    bus_start();
    send_byte(8'hA0, I2C_ACK, "part_addr_ack");
    send_byte(8'h07, I2C_ACK, "part_ptr_ack");
    m_ptr = 7;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    chk_model();
    chk("part_state", 32'(dut.state_q), 32'(IDLE));

    // Reset while the target drives a 0 read bit
    bus_start();
    send_byte(8'hA0, I2C_ACK, "rr_addr_w_ack");
    send_byte(8'h03, I2C_ACK, "rr_ptr_ack");
    m_ptr = 3;
    bus_start();
    send_byte(8'hA1, I2C_ACK, "rr_addr_r_ack");
    read_bit(b);
    chk("rr_bit7", 32'(b), 32'(m_mem[3][7]));
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    chk("rr_bit6_drive", 32'(ifc.sda_o), 32'(m_mem[3][6]));
    rst = 1'b1;
    #1;
    chk("rr_async_release", 32'(ifc.sda_o), 32'd1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_model();
    chk("rr_state", 32'(dut.state_q), 32'(IDLE));
    scl_m = 1'b0; q();
    bus_stop();

    // Served again after reset
    wdata[0] = 8'h5A;
    wr_txn(7'h50, 8'h01, 1);
    chk_model();
    chk("lit_mem1", 32'(dut.mem_q[1]), 32'h0000_005A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
